alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 5-bit alu_control code produced by the ALU control decoder, plus two 32-bit operands, through a valid/ready handshake.
- Logic/arithmetic ops complete in one cycle.
- Shifts use an area-saving iterative 1-bit-per-cycle shifter.
- Provides result, zero flag (branch compare via SUB) and an illegal-op flag to the pipeline control.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- alu_control  input  5  operation code (encoding below).
- operand_a  input  XLEN  rs1 value.
- operand_b  input  XLEN  rs2 or immediate; shifts use operand_b[SHAMT_W-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  registered result.
- zero  output  1  registered, result == 0.
- illegal_op  output  1  registered, code not recognised.

Behaviour:
- Encoding of alu_control:
  - ADD=00000, SUB=00001, AND=00010, OR=00011, XOR=00100
  - SLT=00101 (signed, result 1/0)
  - SLL=00110, SRL=00111, SRA=01000
  - All other codes are illegal.
- Reset: rst_n sampled low at a clk edge forces the following, regardless of state; an in-flight shift is discarded:
  - state=IDLE
  - in_ready=1, out_valid=0
  - result=0, zero=0, illegal_op=0
  - shift counter=0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on the edge where in_valid && in_ready.
  - Non-shift legal op: compute combinationally, register result/zero, illegal_op=0, go to DONE.
  - Illegal op: result=0, zero=1, illegal_op=1, go to DONE.
  - Shift op: load result=operand_a, count=shamt, latch op. If shamt==0, go to DONE with zero=(operand_a==0); else go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: shift result by 1 (SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates bit XLEN-1), then count decrements.
  - When count==1 at the edge, go to DONE and set zero from the final value.
  - Inputs are ignored while in SHIFT.
- DONE:
  - out_valid=1, in_ready=0.
  - result, zero and illegal_op are held stable until out_ready=1.
  - On out_valid && out_ready: go to IDLE and drop out_valid the next cycle.
- Latency, accept edge to out_valid high:
  - 1 cycle for non-shift, illegal, or shamt=0.
  - 1+shamt cycles for shifts (max 32).
- Throughput: at most one op per 2 cycles. No overlap between an accept and a pending result.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; no overflow flag.
  - SLT compares as signed two's complement.
  - Shift amount uses the low SHAMT_W bits only; upper bits of operand_b are ignored.
- Back-pressure: out_ready low holds DONE indefinitely; outputs must not change.
- in_valid asserted outside IDLE has no effect. The producer holds the request until in_ready.

Decomposition:
- Package alu_pkg holds:
  - ALU code localparams (ALU_ADD..ALU_SRA), shared with the ALU control decoder.
  - The state enum (ST_IDLE, ST_SHIFT, ST_DONE).
  - XLEN default.
- Sub-module alu_comb_core: purely combinational single-cycle ops (ADD/SUB/AND/OR/XOR/SLT plus illegal detect). The FSM, counter and shifter stay in alu_exec_unit.

Test Plan:
- Reset mid-SHIFT: accept SLL a=1, b=20; assert rst_n=0 at cycle 5 -> next cycle out_valid=0, in_ready=1, result=0; no stale result appears.
- ADD/SUB: a=0x7FFFFFFF, b=1, ADD -> result 0x80000000 one cycle after accept, zero=0. Then SUB a=5, b=5 -> result 0, zero=1.
- SLT signed: a=0xFFFFFFFF (-1), b=1 -> result 1. Swapped -> result 0. AND 0xF0F0 & 0x0FF0 -> 0x00F0. XOR equal operands -> 0, zero=1.
- Shifts: SRA a=0x80000000, b=4 -> 0xF8000000 with out_valid exactly 5 cycles after accept. SRL same operands -> 0x08000000. SLL a=1, b=0x25 (shamt 5) -> 0x20 after 6 cycles. shamt=0 -> result=a after 1 cycle.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> result, zero and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> one transfer, IDLE next cycle.
- Illegal code 11111, a=3, b=4 -> result 0, illegal_op=1, zero=1 after 1 cycle. A following legal ADD clears illegal_op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   DEFAULT_XLEN      : default operand/result width
//   ALU_ADD..ALU_SRA  : 5-bit alu_control codes, shared with the ALU control decoder
//   ST_IDLE/SHIFT/DONE: execute-unit FSM state codes
package alu_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_XOR = 5'b00100;
   localparam logic [4:0] ALU_SLT = 5'b00101;
   localparam logic [4:0] ALU_SLL = 5'b00110;
   localparam logic [4:0] ALU_SRL = 5'b00111;
   localparam logic [4:0] ALU_SRA = 5'b01000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic is_shift_op(input logic [4:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle combinational ALU operations.
//   alu_control : operation code
//   operand_a/b : operands
//   core_result : ADD/SUB/AND/OR/XOR/SLT result (0 for any other code)
//   core_illegal: code is not a recognised operation (shift codes are legal)
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic [4:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic [XLEN-1:0] core_result,
   output logic            core_illegal
);

   always_comb begin
      core_result  = '0;
      core_illegal = 1'b0;
      case (alu_control)
         ALU_ADD: core_result = operand_a + operand_b;
         ALU_SUB: core_result = operand_a - operand_b;
         ALU_AND: core_result = operand_a & operand_b;
         ALU_OR:  core_result = operand_a | operand_b;
         ALU_XOR: core_result = operand_a ^ operand_b;
         ALU_SLT: core_result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         ALU_SLL, ALU_SRL, ALU_SRA: core_result = '0;
         default: core_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle; shifts run one bit per cycle.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake (alu_control, operand_a, operand_b)
//   out_valid / out_ready: result handshake (result, zero, illegal_op)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a request; accept computes or loads the shifter
// ST_SHIFT | shifting result by one bit per cycle, cnt bits remaining
// ST_DONE  | result held on outputs until out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = DEFAULT_XLEN,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal_op
);

   logic [1:0]         state;
   logic [SHAMT_W-1:0] cnt;
   logic [4:0]         shift_op;
   logic [XLEN-1:0]    core_result;
   logic               core_illegal;
   logic [XLEN-1:0]    shifted;
   logic [SHAMT_W-1:0] shamt;

   assign shamt     = operand_b[SHAMT_W-1:0];
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   alu_comb_core #(.XLEN(XLEN)) u_core (
      .alu_control  (alu_control),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .core_result  (core_result),
      .core_illegal (core_illegal)
   );

   always_comb begin
      shifted = result;
      case (shift_op)
         ALU_SLL: shifted = {result[XLEN-2:0], 1'b0};
         ALU_SRL: shifted = {1'b0, result[XLEN-1:1]};
         ALU_SRA: shifted = {result[XLEN-1], result[XLEN-1:1]};
         default: shifted = result;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         result     <= '0;
         zero       <= 1'b0;
         illegal_op <= 1'b0;
         cnt        <= '0;
         shift_op   <= ALU_SLL;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (is_shift_op(alu_control)) begin
                     result     <= operand_a;
                     cnt        <= shamt;
                     shift_op   <= alu_control;
                     illegal_op <= 1'b0;
                     zero       <= (operand_a == '0);
                     state      <= (shamt == '0) ? ST_DONE : ST_SHIFT;
                  end else if (core_illegal) begin
                     result     <= '0;
                     zero       <= 1'b1;
                     illegal_op <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     result     <= core_result;
                     zero       <= (core_result == '0);
                     illegal_op <= 1'b0;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               result <= shifted;
               cnt    <= cnt - 1'b1;
               if (cnt == SHAMT_W'(1)) begin
                  zero  <= (shifted == '0);
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
